// File: rtl/manual_drive_pkg.sv
// manual_drive_pkg: state encodings and engine power levels shared by the manual drive controller
package manual_drive_pkg;

    typedef enum logic [1:0] {
        S_OFF          = 2'd0,
        S_NOT_STARTING = 2'd1,
        S_STARTING     = 2'd2,
        S_MOVING       = 2'd3
    } state_t;

    localparam logic POFF = 1'b0;
    localparam logic PON  = 1'b1;

endpackage

// File: rtl/manual_drive_tick_counter.sv
// manual_drive_tick_counter: modulo-N counter of enabled tick_ms strobes with a one-cycle wrap pulse
module manual_drive_tick_counter #(
    parameter int N = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_ms,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = N > 1 ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    assign wrap = en & tick_ms & (cnt == W'(N - 1));

    // count enabled ticks, restart on wrap or clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && tick_ms)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/manual_drive.sv
// manual_drive: manual driving-mode FSM with stall power-off, reverse latch, mileage and turn lamps
module manual_drive
    import manual_drive_pkg::*;
#(
    parameter int MILE_TICKS  = 1000,
    parameter int BLINK_TICKS = 500,
    parameter int MILE_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_ms,
    input  logic              power,
    input  logic              throttle,
    input  logic              clutch,
    input  logic              brake,
    input  logic              reverse,
    input  logic              turn_left,
    input  logic              turn_right,
    output logic              manual_power,
    output logic [1:0]        state,
    output logic              dir_rev,
    output logic              move_fwd,
    output logic              move_back,
    output logic              lamp_left,
    output logic              lamp_right,
    output logic [MILE_W-1:0] mileage
);

    state_t st;
    logic   rev_q;
    logic   rev_chg;
    logic   stall;
    logic   to_off;
    logic   mile_wrap;
    logic   blink_clr;
    logic   blink_wrap;
    logic   dark;

    assign state     = st;
    assign rev_chg   = reverse ^ rev_q;
    // brake always rescues a would-be stall back to NOT_STARTING
    assign stall     = ~brake & ((st == S_NOT_STARTING) ? (throttle & ~clutch)
                                                        : ((st != S_OFF) & rev_chg & ~clutch));
    assign to_off    = ~power | stall;
    assign blink_clr = ~(turn_left | turn_right) | to_off;

    manual_drive_tick_counter #(.N(MILE_TICKS)) u_mile (
        .clk     (clk),
        .rst     (rst),
        .tick_ms (tick_ms),
        .en      (st == S_MOVING),
        .clr     (st != S_MOVING),
        .wrap    (mile_wrap)
    );

    manual_drive_tick_counter #(.N(BLINK_TICKS)) u_blink (
        .clk     (clk),
        .rst     (rst),
        .tick_ms (tick_ms),
        .en      (~blink_clr),
        .clr     (blink_clr),
        .wrap    (blink_wrap)
    );

    // driving FSM with registered power request, reverse latch and motion indicators
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st           <= S_OFF;
            manual_power <= POFF;
            dir_rev      <= 1'b0;
            rev_q        <= 1'b0;
            move_fwd     <= 1'b0;
            move_back    <= 1'b0;
        end else begin
            rev_q     <= reverse;
            move_fwd  <= 1'b0;
            move_back <= 1'b0;
            if (to_off) begin
                st           <= S_OFF;
                manual_power <= POFF;
            end else begin
                manual_power <= PON;
                case (st)
                    S_OFF: st <= S_NOT_STARTING;
                    S_NOT_STARTING: begin
                        if (rev_chg)
                            dir_rev <= reverse;
                        if (!brake && throttle && clutch)
                            st <= S_STARTING;
                    end
                    S_STARTING: begin
                        if (brake)
                            st <= S_NOT_STARTING;
                        else if (rev_chg)
                            dir_rev <= reverse;
                        else if (throttle && !clutch) begin
                            st        <= S_MOVING;
                            move_fwd  <= ~dir_rev;
                            move_back <= dir_rev;
                        end
                    end
                    S_MOVING: begin
                        if (brake)
                            st <= S_NOT_STARTING;
                        else if (clutch || !throttle)
                            st <= S_STARTING;
                        else begin
                            move_fwd  <= ~dir_rev;
                            move_back <= dir_rev;
                        end
                    end
                endcase
            end
        end
    end

    // mileage survives state changes, only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mileage <= '0;
        else if (mile_wrap)
            mileage <= mileage + 1'b1;
    end

    // shared blink phase keeps both lamps in step; lamps start lit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dark       <= 1'b0;
            lamp_left  <= 1'b0;
            lamp_right <= 1'b0;
        end else begin
            dark       <= ~blink_clr & (dark ^ blink_wrap);
            lamp_left  <= turn_left & ~to_off & ~(dark ^ blink_wrap);
            lamp_right <= turn_right & ~to_off & ~(dark ^ blink_wrap);
        end
    end

endmodule
